// File: rtl/multi_timer.sv
// multi_timer: NumChannels prescaled up-counters, each with a compare value, one-shot/periodic mode and a W1C pending bit.
// Latency: bus response is registered and arrives one cycle after the request; interrupts are combinational from registered pending/IE.
// Backpressure: none. A request is accepted every cycle and answered exactly once, so back-to-back requests get one response per cycle.
// Ports: clk_i/rst_i single clock, synchronous active-high reset; timer_req/we/be/addr/wdata request,
//        timer_rvalid/rdata/err response; timer_intr_o per-channel interrupt (pending & IE); timer_irq_o OR of timer_intr_o.
// Register map, per channel at 0x10*n: 0x0 CTRL {IE,MODE,EN}, 0x4 PRESCALE, 0x8 COMPARE, 0xC COUNT; 0x200 INTR_STATUS (W1C).
module multi_timer #(
  parameter int NumChannels   = 4,
  parameter int CounterWidth  = 32,
  parameter int PrescaleWidth = 16,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    timer_req_i,
  input  logic                    timer_we_i,
  input  logic [3:0]              timer_be_i,
  input  logic [AddressWidth-1:0] timer_addr_i,
  input  logic [DataWidth-1:0]    timer_wdata_i,
  output logic                    timer_rvalid_o,
  output logic [DataWidth-1:0]    timer_rdata_o,
  output logic                    timer_err_o,
  output logic [NumChannels-1:0]  timer_intr_o,
  output logic                    timer_irq_o
);

  localparam logic [1:0] RegCtrl     = 2'd0;
  localparam logic [1:0] RegPrescale = 2'd1;
  localparam logic [1:0] RegCompare  = 2'd2;
  localparam logic [1:0] RegCount    = 2'd3;
  // INTR_STATUS at byte offset 0x200, expressed as a word index
  localparam logic [7:0] StatusWord  = 8'h80;

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic [NumChannels-1:0]   en_q;
  logic [NumChannels-1:0]   mode_q;
  logic [NumChannels-1:0]   ie_q;
  logic [NumChannels-1:0]   pending_q;
  logic [PrescaleWidth-1:0] prescale_q  [NumChannels];
  logic [PrescaleWidth-1:0] presc_cnt_q [NumChannels];
  logic [CounterWidth-1:0]  compare_q   [NumChannels];
  logic [CounterWidth-1:0]  count_q     [NumChannels];

  // ---------------------------------------------------------------------------
  // Address decode: only addr[9:2] select a register
  // ---------------------------------------------------------------------------
  logic [9:0] offset;
  logic [3:0] ch_idx;
  logic [1:0] reg_sel;
  logic       is_status;
  logic       is_chan;
  logic       addr_ok;
  logic       bus_wr;

  assign offset    = timer_addr_i[9:0];
  assign ch_idx    = offset[7:4];
  assign reg_sel   = offset[3:2];
  assign is_status = (offset[9:2] == StatusWord);
  assign is_chan   = (offset[9:8] == 2'b00) && (int'(ch_idx) < NumChannels);
  assign addr_ok   = is_status || is_chan;
  assign bus_wr    = timer_req_i && timer_we_i && addr_ok;

  // Upper address bits and the byte-within-word bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{timer_addr_i[AddressWidth-1:10], offset[1:0]};

  // Byte-lane merge of write data into the current register value.
  function automatic logic [DataWidth-1:0] be_merge(input logic [DataWidth-1:0] cur,
                                                    input logic [DataWidth-1:0] wd,
                                                    input logic [3:0]           be);
    logic [DataWidth-1:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? wd[8*b +: 8] : cur[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational: current value of the addressed register, per-channel
  // write strobes, prescaler ticks and compare events.
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0]   rd_cur;
  logic [DataWidth-1:0]   wr_word;
  logic [NumChannels-1:0] ch_wr;
  logic [NumChannels-1:0] tick;
  logic [NumChannels-1:0] evt;
  logic [NumChannels-1:0] status_clr;

  always_comb begin
    rd_cur = '0;
    if (is_status) begin
      rd_cur[NumChannels-1:0] = pending_q;
    end
    for (int i = 0; i < NumChannels; i++) begin
      ch_wr[i] = bus_wr && is_chan && (ch_idx == 4'(i));
      if (is_chan && (ch_idx == 4'(i))) begin
        case (reg_sel)
          RegCtrl:     rd_cur[2:0]               = {ie_q[i], mode_q[i], en_q[i]};
          RegPrescale: rd_cur[PrescaleWidth-1:0] = prescale_q[i];
          RegCompare:  rd_cur[CounterWidth-1:0]  = compare_q[i];
          default:     rd_cur[CounterWidth-1:0]  = count_q[i];
        endcase
      end
      tick[i] = en_q[i] && (presc_cnt_q[i] == prescale_q[i]);
      evt[i]  = tick[i] && (count_q[i] == compare_q[i]);
      // W1C honours byte enables: bit i lives in byte lane i/8.
      status_clr[i] = bus_wr && is_status && timer_wdata_i[i] && timer_be_i[i/8];
    end
  end

  // Writes only replace the enabled byte lanes of the addressed register.
  assign wr_word = be_merge(rd_cur, timer_wdata_i, timer_be_i);

  // ---------------------------------------------------------------------------
  // Sequential: bus response and channel state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_rvalid_o <= 1'b0;
      timer_rdata_o  <= '0;
      timer_err_o    <= 1'b0;
      en_q           <= '0;
      mode_q         <= '0;
      ie_q           <= '0;
      pending_q      <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        prescale_q[i]  <= '0;
        presc_cnt_q[i] <= '0;
        compare_q[i]   <= '0;
        count_q[i]     <= '0;
      end
    end else begin
      // Response reflects state before this edge; writes and errors return 0.
      timer_rvalid_o <= timer_req_i;
      timer_err_o    <= timer_req_i && !addr_ok;
      timer_rdata_o  <= (timer_req_i && !timer_we_i && addr_ok) ? rd_cur : '0;

      // A new event beats a simultaneous W1C of the same bit.
      pending_q <= (pending_q & ~status_clr) | evt;

      for (int i = 0; i < NumChannels; i++) begin
        // A COUNT write overrides the tick and restarts the prescaler.
        if (ch_wr[i] && (reg_sel == RegCount)) begin
          count_q[i]     <= wr_word[CounterWidth-1:0];
          presc_cnt_q[i] <= '0;
        end else begin
          if (evt[i]) begin
            count_q[i] <= '0;
          end else if (tick[i]) begin
            count_q[i] <= count_q[i] + CounterWidth'(1);
          end
          presc_cnt_q[i] <= (!en_q[i] || tick[i]) ? '0 : presc_cnt_q[i] + PrescaleWidth'(1);
        end

        // A CTRL write decides EN even when a one-shot event fires this cycle.
        if (ch_wr[i] && (reg_sel == RegCtrl)) begin
          en_q[i]   <= wr_word[0];
          mode_q[i] <= wr_word[1];
          ie_q[i]   <= wr_word[2];
        end else if (evt[i] && !mode_q[i]) begin
          en_q[i] <= 1'b0;
        end

        if (ch_wr[i] && (reg_sel == RegPrescale)) begin
          prescale_q[i] <= wr_word[PrescaleWidth-1:0];
        end
        if (ch_wr[i] && (reg_sel == RegCompare)) begin
          compare_q[i] <= wr_word[CounterWidth-1:0];
        end
      end
    end
  end

  assign timer_intr_o = pending_q & ie_q;
  assign timer_irq_o  = |timer_intr_o;

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel timer peripheral for the simple system bus. It replaces the single-channel timer as the bus device behind the 1 kB timer window. It provides `NumChannels` independent up-counters, each with:

- a prescaler,
- a compare value,
- one-shot or periodic mode,
- a per-channel interrupt.

Pending bits are aggregated into a per-channel interrupt vector and a single core timer interrupt.

## Interface

Reset is synchronous and active-high; all state clears on the `clk_i` edge where `rst_i` is high.

Parameters:

- `NumChannels`, 4 — number of timer channels; legal range 1..16.
- `CounterWidth`, 32 — counter and compare width in bits; legal range 8..32.
- `PrescaleWidth`, 16 — prescaler width in bits; legal range 1..16.
- `DataWidth`, 32 — bus data width; fixed at 32.
- `AddressWidth`, 32 — bus address width; only bits [9:0] are decoded.

Ports:

- `clk_i` in 1 — single clock.
- `rst_i` in 1 — synchronous, active-high reset.
- `timer_req_i` in 1 — bus request; accepted every cycle, no grant.
- `timer_we_i` in 1 — write enable.
- `timer_be_i` in 4 — byte enables; writes update only enabled bytes.
- `timer_addr_i` in AddressWidth — byte address.
- `timer_wdata_i` in 32 — write data.
- `timer_rvalid_o` out 1 — response valid, one cycle after request.
- `timer_rdata_o` out 32 — read data; 0 for writes and errors.
- `timer_err_o` out 1 — error response, valid with `timer_rvalid_o`.
- `timer_intr_o` out NumChannels — per-channel interrupt: `pending[n] & IE[n]`.
- `timer_irq_o` out 1 — OR of `timer_intr_o`.

## Operation

Register map (offset = `addr[9:0]`, word aligned, `addr[1:0]` ignored):

- Channel n registers sit at 0x10*n + the offsets below.
  - 0x0 CTRL: bit0 EN, bit1 MODE (0 one-shot, 1 periodic), bit2 IE; other bits read 0.
  - 0x4 PRESCALE: [PrescaleWidth-1:0].
  - 0x8 COMPARE: [CounterWidth-1:0].
  - 0xC COUNT: [CounterWidth-1:0]; read/write. A write also clears the channel prescaler.
- 0x200 INTR_STATUS: bit n = pending[n]. Read returns the vector; a write of 1 clears the bit (W1C), a write of 0 has no effect.
- Any other offset, or a channel index ≥ NumChannels: err=1, rdata=0, no state change.

Channel counting:

- While EN=0, the prescaler is held at 0 and COUNT holds its value.
- While EN=1, the prescaler increments every cycle. When it equals PRESCALE it wraps to 0 and issues a tick.
- On a tick:
  - If COUNT == COMPARE, an event fires: pending[n] is set and COUNT becomes 0. In one-shot mode EN is also cleared.
  - Otherwise COUNT increments, modulo 2^CounterWidth.
- Event period is (COMPARE+1)*(PRESCALE+1) cycles.
- If COUNT > COMPARE, the counter wraps through 0 before the event.

Simultaneous events:

- A bus write to COUNT in the same cycle as a tick: the write wins and no increment occurs.
- A bus write to CTRL in the same cycle as a one-shot event: pending is still set, and EN takes the written value.
- A W1C of pending[n] in the same cycle as a new event on channel n: the set wins.
- Writes to COMPARE or PRESCALE take effect from the next cycle; the running count is not reset.

## Timing

- Bus: a request sampled at edge t gives rvalid/rdata/err valid in the cycle after t, high for exactly one cycle.
  - Back-to-back requests are supported with one response per cycle.
  - Write state updates at edge t; a read at t+1 returns the new value.
- Read data is registered and reflects state before edge t.
- Interrupts: `timer_intr_o` and `timer_irq_o` are combinational from registered pending/IE, so they are visible in the cycle after the event edge. No further latency.
- Reset values: every register 0, all pending bits 0, prescalers 0. Outputs rvalid/rdata/err/intr/irq are all 0.
- Reset asserted mid-count or mid-transaction: state clears at that edge and no response is issued for a request sampled during reset.

## Test plan

- Reset then read every register of every channel -> all read 0, err=0; read at 0x0F0 with NumChannels=4 -> err=1, rdata=0.
- Channel 0: PRESCALE=0, COMPARE=3, CTRL=0b111 (EN, periodic, IE) written at edge E0 -> `timer_intr_o[0]` rises after E4. After W1C of bit0, the next event comes after E8; the period stays at 4 cycles.
- Channel 1: PRESCALE=2, COMPARE=1, one-shot with IE -> pending set 6 cycles after enable. CTRL reads 0b100 (EN cleared), COUNT reads 0, and no second event occurs within 100 cycles.
- Boundary, CounterWidth=8: COUNT=0xFE, COMPARE=0x01, PRESCALE=0 -> COUNT goes 0xFF, 0x00, 0x01, then an event on the 4th tick.
- Collisions:
  - A COUNT write of 0x10 coinciding with a tick -> COUNT reads 0x10.
  - A W1C coinciding with an event -> pending stays 1.
- Byte enables: write 0xAABBCCDD to COMPARE with be=0b0010 -> COMPARE reads 0x0000CC00. Channels 0..3 all periodic with different COMPAREs -> `timer_irq_o` is the OR of the individual pending bits each cycle.
